// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the periodic SPI ADC scan controller.
//   - scan FSM state encoding (state_t + ST_* constants)
//   - SPI command word pieces and per-channel command constants
//   - default SPI clock divider constant
package adc_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_CONV  = 3'd3;
  localparam state_t ST_NEXT  = 3'd4;

  localparam logic [5:0] CMD_BASE = 6'b010111;
  localparam logic [7:0] CMD_CH0  = {1'b1, 1'b0, CMD_BASE};
  localparam logic [7:0] CMD_CH1  = {1'b1, 1'b1, CMD_BASE};

  // 800 ns SCLK at 100 MHz
  localparam logic [7:0] KMAX_DEFAULT = 8'd39;

  function automatic logic [7:0] cmd_word(input logic ch);
    return {1'b1, ch, CMD_BASE};
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// adc_scan_ctrl_if: control/data handshake between the scan controller and spi_wr.
//   strc  : one-cycle conversion start pulse (controller -> spi_wr)
//   cmd   : 8-bit command word           (controller -> spi_wr)
//   kmax  : SPI clock divider constant   (controller -> spi_wr)
//   eoc   : end-of-conversion pulse      (spi_wr -> controller)
//   dout  : 12-bit result, valid with eoc (spi_wr -> controller)
interface adc_scan_ctrl_if;
  logic        strc;
  logic [7:0]  cmd;
  logic [7:0]  kmax;
  logic        eoc;
  logic [11:0] dout;

  modport master (output strc, cmd, kmax, input eoc, dout);
  modport slave  (input strc, cmd, kmax, output eoc, dout);
endinterface

// File: rtl/adc_scan_ctrl_period_timer.sv
// period_timer: free-running period counter for the scan scheduler.
//   clk_i, rst_i : clock, async active-high reset
//   hold_i       : holds the counter at 0 and suppresses the tick
//   period_i     : period minus 1
//   tick_o       : high in the cycle where count == period_i (counter wraps after)
module period_timer #(
  parameter int PER_W = 29
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic [PER_W-1:0] period_i,
  output logic             tick_o
);

  logic [PER_W-1:0] cnt_q, cnt_d;

  assign tick_o = !hold_i && (cnt_q == period_i);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (hold_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: periodic two-channel scan scheduler driving spi_wr.
//   clk_i, rst_i   : clock, async active-high reset
//   en_i           : scanning enable
//   period_i       : scan period minus 1 (start-to-start, clk_i cycles)
//   chmask_i       : channel enable mask, sampled at each period tick
//   clr_i          : clears sticky overrun_o / err_o
//   spi            : strc/cmd/kmax out, eoc/dout in (adc_scan_ctrl_if.master)
//   data0_o/1_o    : last result per channel
//   valid_o, vch_o : new-result pulse and its channel
//   scan_done_o    : pulse at end of each scan
//   busy_o         : scan in progress (START/CONV/NEXT)
//   overrun_o      : sticky, tick landed inside a scan
//   err_o          : sticky, eoc timeout
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int         PER_W   = 29,
  parameter int         TIMEOUT = 4095,
  parameter logic [7:0] KMAX    = KMAX_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [PER_W-1:0]       period_i,
  input  logic [1:0]             chmask_i,
  input  logic                   clr_i,
  adc_scan_ctrl_if.master        spi,
  output logic [11:0]            data0_o,
  output logic [11:0]            data1_o,
  output logic                   valid_o,
  output logic                   vch_o,
  output logic                   scan_done_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   err_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic             ch_q, ch_d;
  logic [1:0]       mask_q, mask_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic             strc_q, strc_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [1:0][11:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             vch_q, vch_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic             err_q, err_d;
  logic             tick, err_set, ovr_set;

  period_timer #(.PER_W(PER_W)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (state_q == ST_IDLE),
    .period_i (period_i),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    tcnt_d  = tcnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    vch_d   = vch_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: if (en_i && (chmask_i != 2'b00)) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!en_i) state_d = ST_IDLE;       // disabled while idle between scans
        else if (tick) begin
          mask_d  = chmask_i;
          ch_d    = (chmask_i == 2'b10);    // lowest set bit
          // empty mask: run an empty scan straight to NEXT
          state_d = (chmask_i == 2'b00) ? ST_NEXT : ST_START;
        end
      end
      ST_START: begin
        tcnt_d  = '0;
        state_d = ST_CONV;
      end
      ST_CONV: begin
        if (spi.eoc) begin
          data_d[ch_q] = spi.dout;
          valid_d      = 1'b1;
          vch_d        = ch_q;
          state_d      = ST_NEXT;
        end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          // TIMEOUT CONV cycles elapsed without eoc
          err_set = 1'b1;
          state_d = ST_NEXT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_NEXT: begin
        if (!ch_q && mask_q[1]) begin
          ch_d    = 1'b1;
          state_d = ST_START;
        end else begin
          done_d  = 1'b1;
          state_d = en_i ? ST_WAIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ovr_set = tick && (state_q inside {ST_START, ST_CONV, ST_NEXT});
    // outputs registered off the next state so they line up with it
    strc_d  = (state_d == ST_START);
    busy_d  = (state_d inside {ST_START, ST_CONV, ST_NEXT});
    cmd_d   = (state_d == ST_START) ? cmd_word(ch_d) : cmd_q;
    // set beats clear
    ovr_d   = ovr_set || (ovr_q && !clr_i);
    err_d   = err_set || (err_q && !clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ch_q    <= 1'b0;
      mask_q  <= 2'b00;
      tcnt_q  <= '0;
      strc_q  <= 1'b0;
      cmd_q   <= CMD_CH0;
      data_q  <= '0;
      valid_q <= 1'b0;
      vch_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      tcnt_q  <= tcnt_d;
      strc_q  <= strc_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      vch_q   <= vch_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  assign spi.strc    = strc_q;
  assign spi.cmd     = cmd_q;
  assign spi.kmax    = KMAX;
  assign data0_o     = data_q[0];
  assign data1_o     = data_q[1];
  assign valid_o     = valid_q;
  assign vch_o       = vch_q;
  assign scan_done_o = done_q;
  assign busy_o      = busy_q;
  assign overrun_o   = ovr_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed bench for adc_scan_ctrl with an spi_wr responder model.
module tb_adc_scan_ctrl;

  logic        clk, rst, en, clr;
  logic [28:0] period;
  logic [1:0]  chmask;
  logic [11:0] data0, data1;
  logic        valid, vch, scan_done, busy, overrun, err;

  adc_scan_ctrl_if spi ();

  adc_scan_ctrl #(.PER_W(29), .TIMEOUT(4095), .KMAX(8'd39)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .period_i(period), .chmask_i(chmask),
    .clr_i(clr), .spi(spi), .data0_o(data0), .data1_o(data1), .valid_o(valid),
    .vch_o(vch), .scan_done_o(scan_done), .busy_o(busy), .overrun_o(overrun),
    .err_o(err)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // spi_wr model: eoc resp_dly cycles after strc for enabled channels
  int         resp_dly = 100;
  logic [1:0] resp_mask = 2'b11;
  logic [11:0] d0v = '0, d1v = '0;
  bit         resp_busy = 0;
  logic       rch;
  initial begin
    spi.eoc = 0; spi.dout = 12'hEEE;
    forever begin
      @(negedge clk);
      if (!rst && spi.strc && resp_mask[spi.cmd[6]]) begin
        rch = spi.cmd[6];
        resp_busy = 1;
        repeat (resp_dly) @(negedge clk);
        spi.eoc = 1; spi.dout = rch ? d1v : d0v;
        @(negedge clk);
        spi.eoc = 0; spi.dout = 12'hEEE;
        resp_busy = 0;
      end
    end
  end

  // event logs
  int         strc_t[$];
  logic [7:0] strc_cmd[$];
  logic       vch_log[$];
  int         done_cnt = 0;
  bit         err_seen = 0;
  int         err_t = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (spi.strc) begin strc_t.push_back(cyc); strc_cmd.push_back(spi.cmd); end
      if (valid) vch_log.push_back(vch);
      if (scan_done) done_cnt++;
      if (err && !err_seen) begin err_seen = 1; err_t = cyc; end
    end
  end

  task automatic do_reset();
    en = 0; chmask = 2'b00; clr = 0;
    for (int i = 0; i < 4000 && resp_busy; i++) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    strc_t.delete(); strc_cmd.delete(); vch_log.delete();
    done_cnt = 0; err_seen = 0;
    #2 rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; clr = 0; chmask = 2'b11; period = 29'd9;
    repeat (2) @(negedge clk);
    n_vec++; if (spi.strc !== 1'b0)    begin n_err++; $display("FAIL rst_strc got %b want 0", spi.strc); end
    n_vec++; if (spi.cmd !== 8'h97)    begin n_err++; $display("FAIL rst_cmd got %h want 97", spi.cmd); end
    n_vec++; if (spi.kmax !== 8'd39)   begin n_err++; $display("FAIL rst_kmax got %0d want 39", spi.kmax); end
    n_vec++; if (data0 !== 12'h000)    begin n_err++; $display("FAIL rst_data0 got %h want 000", data0); end
    n_vec++; if (data1 !== 12'h000)    begin n_err++; $display("FAIL rst_data1 got %h want 000", data1); end
    n_vec++; if ({valid, vch, scan_done, busy, overrun, err} !== 6'b0)
      begin n_err++; $display("FAIL rst_flags got %b want 000000", {valid, vch, scan_done, busy, overrun, err}); end
    // disabled: never leaves IDLE
    #2 rst = 0;
    repeat (30) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || strc_t.size() != 0)
      begin n_err++; $display("FAIL rst_idle busy=%b strcs=%0d want 0/0", busy, strc_t.size()); end
  endtask

  task automatic test_basic();
    do_reset();
    period = 29'd999; chmask = 2'b11; resp_dly = 1500; resp_mask = 2'b11;
    d0v = 12'hA5A; d1v = 12'h3C3; en = 1;
    for (int i = 0; i < 6000 && done_cnt < 1; i++) @(negedge clk);
    en = 0;
    @(negedge clk);
    n_vec++; if (done_cnt != 1)        begin n_err++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    n_vec++; if (data0 !== 12'hA5A)    begin n_err++; $display("FAIL basic_data0 got %h want A5A", data0); end
    n_vec++; if (data1 !== 12'h3C3)    begin n_err++; $display("FAIL basic_data1 got %h want 3C3", data1); end
    n_vec++; if (strc_t.size() != 2)   begin n_err++; $display("FAIL basic_nstrc got %0d want 2", strc_t.size()); end
    n_vec++; if (strc_cmd[0] !== 8'h97) begin n_err++; $display("FAIL basic_cmd0 got %h want 97", strc_cmd[0]); end
    n_vec++; if (strc_cmd[1] !== 8'hD7) begin n_err++; $display("FAIL basic_cmd1 got %h want D7", strc_cmd[1]); end
    n_vec++; if (strc_t[1] - strc_t[0] != 1502)
      begin n_err++; $display("FAIL basic_gap got %0d want 1502", strc_t[1] - strc_t[0]); end
    n_vec++; if (vch_log.size() != 2 || vch_log[0] !== 1'b0 || vch_log[1] !== 1'b1)
      begin n_err++; $display("FAIL basic_vch got n=%0d want 2 valids ch0,ch1", vch_log.size()); end
    n_vec++; if (spi.cmd !== 8'hD7)    begin n_err++; $display("FAIL basic_cmd_hold got %h want D7", spi.cmd); end
  endtask

  task automatic test_single();
    do_reset();
    period = 29'd4999; chmask = 2'b10; resp_dly = 100; resp_mask = 2'b11;
    d0v = 12'h111; d1v = 12'h5E1; en = 1;
    for (int i = 0; i < 12000 && done_cnt < 2; i++) @(negedge clk);
    en = 0;
    @(negedge clk);
    n_vec++; if (strc_t.size() != 2)   begin n_err++; $display("FAIL single_nstrc got %0d want 2", strc_t.size()); end
    n_vec++; if (strc_t[1] - strc_t[0] != 5000)
      begin n_err++; $display("FAIL single_gap got %0d want 5000", strc_t[1] - strc_t[0]); end
    n_vec++; if (strc_cmd[0] !== 8'hD7 || strc_cmd[1] !== 8'hD7)
      begin n_err++; $display("FAIL single_cmd got %h/%h want D7/D7", strc_cmd[0], strc_cmd[1]); end
    n_vec++; if (data0 !== 12'h000)    begin n_err++; $display("FAIL single_data0 got %h want 000", data0); end
    n_vec++; if (data1 !== 12'h5E1)    begin n_err++; $display("FAIL single_data1 got %h want 5E1", data1); end
    n_vec++; if (vch_log.size() != 2 || vch_log[0] !== 1'b1 || vch_log[1] !== 1'b1)
      begin n_err++; $display("FAIL single_vch got n=%0d want 2 valids on ch1", vch_log.size()); end
    n_vec++; if (overrun !== 1'b0)     begin n_err++; $display("FAIL single_ovr got %b want 0", overrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    period = 29'd99; chmask = 2'b01; resp_dly = 1500; resp_mask = 2'b11;
    d0v = 12'h111; en = 1;
    for (int i = 0; i < 3000 && done_cnt < 1; i++) @(negedge clk);
    n_vec++; if (overrun !== 1'b1)     begin n_err++; $display("FAIL ovr_set got %b want 1", overrun); end
    n_vec++; if (data0 !== 12'h111)    begin n_err++; $display("FAIL ovr_data0 got %h want 111", data0); end
    @(negedge clk);
    for (int i = 0; i < 3200 && !scan_done; i++) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    n_vec++; if (overrun !== 1'b0)     begin n_err++; $display("FAIL ovr_clr got %b want 0", overrun); end
    for (int i = 0; i < 400 && !overrun; i++) @(negedge clk);
    n_vec++; if (overrun !== 1'b1)     begin n_err++; $display("FAIL ovr_reset got %b want 1", overrun); end
    n_vec++; if (strc_t.size() < 3)    begin n_err++; $display("FAIL ovr_continue got %0d strcs want >=3", strc_t.size()); end
    en = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    period = 29'd4999; chmask = 2'b11; resp_dly = 300; resp_mask = 2'b10;
    d1v = 12'h7C1; en = 1;
    for (int i = 0; i < 11000 && done_cnt < 1; i++) @(negedge clk);
    en = 0;
    @(negedge clk);
    n_vec++; if (err !== 1'b1)         begin n_err++; $display("FAIL to_err got %b want 1", err); end
    n_vec++; if (err_t - strc_t[0] != 4096)
      begin n_err++; $display("FAIL to_err_time got %0d want 4096", err_t - strc_t[0]); end
    n_vec++; if (strc_t.size() != 2 || strc_cmd[1] !== 8'hD7)
      begin n_err++; $display("FAIL to_next got n=%0d cmd=%h want 2/D7", strc_t.size(), strc_cmd[1]); end
    n_vec++; if (strc_t[1] - strc_t[0] != 4097)
      begin n_err++; $display("FAIL to_gap got %0d want 4097", strc_t[1] - strc_t[0]); end
    n_vec++; if (vch_log.size() != 1 || vch_log[0] !== 1'b1)
      begin n_err++; $display("FAIL to_valid got n=%0d want one ch1 valid", vch_log.size()); end
    n_vec++; if (data0 !== 12'h000 || data1 !== 12'h7C1)
      begin n_err++; $display("FAIL to_data got %h/%h want 000/7C1", data0, data1); end
    clr = 1;
    @(negedge clk);
    clr = 0;
    n_vec++; if (err !== 1'b0)         begin n_err++; $display("FAIL to_clr got %b want 0", err); end
  endtask

  task automatic test_en_mask();
    do_reset();
    period = 29'd999; chmask = 2'b11; resp_dly = 200; resp_mask = 2'b11;
    d0v = 12'h0AB; d1v = 12'h0CD; en = 1;
    for (int i = 0; i < 1500 && strc_t.size() < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    en = 0;
    for (int i = 0; i < 1000 && done_cnt < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_vec++; if (strc_t.size() != 2 || vch_log.size() != 2)
      begin n_err++; $display("FAIL en_complete got strc=%0d valid=%0d want 2/2", strc_t.size(), vch_log.size()); end
    n_vec++; if (data1 !== 12'h0CD)    begin n_err++; $display("FAIL en_data1 got %h want 0CD", data1); end
    repeat (2000) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || strc_t.size() != 2 || done_cnt != 1)
      begin n_err++; $display("FAIL en_idle got busy=%b strc=%0d done=%0d want 0/2/1", busy, strc_t.size(), done_cnt); end

    do_reset();
    period = 29'd99; chmask = 2'b01; en = 1;
    repeat (3) @(negedge clk);
    chmask = 2'b00;
    for (int i = 0; i < 300 && done_cnt < 1; i++) @(negedge clk);
    @(negedge clk);
    n_vec++; if (done_cnt != 1)        begin n_err++; $display("FAIL mask0_done got %0d want 1", done_cnt); end
    n_vec++; if (strc_t.size() != 0 || vch_log.size() != 0)
      begin n_err++; $display("FAIL mask0_traffic got strc=%0d valid=%0d want 0/0", strc_t.size(), vch_log.size()); end
    en = 0;
  endtask

  task automatic test_reset_mid();
    int rel_t;
    do_reset();
    period = 29'd999; chmask = 2'b10; resp_dly = 1500; resp_mask = 2'b11;
    d1v = 12'h3C3; en = 1;
    for (int i = 0; i < 4000 && done_cnt < 1; i++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2000 && !spi.strc; i++) @(negedge clk);
    n_vec++; if (spi.strc !== 1'b1 || data1 !== 12'h3C3 || overrun !== 1'b1 || vch !== 1'b1)
      begin n_err++; $display("FAIL rmid_pre got strc=%b d1=%h ovr=%b vch=%b want 1/3C3/1/1", spi.strc, data1, overrun, vch); end
    #1 rst = 1;
    #1;
    n_vec++; if (spi.strc !== 1'b0)    begin n_err++; $display("FAIL rmid_strc got %b want 0", spi.strc); end
    n_vec++; if (spi.cmd !== 8'h97)    begin n_err++; $display("FAIL rmid_cmd got %h want 97", spi.cmd); end
    n_vec++; if (data1 !== 12'h000)    begin n_err++; $display("FAIL rmid_data1 got %h want 000", data1); end
    n_vec++; if ({valid, vch, scan_done, busy, overrun, err} !== 6'b0)
      begin n_err++; $display("FAIL rmid_flags got %b want 000000", {valid, vch, scan_done, busy, overrun, err}); end
    repeat (2) @(negedge clk);
    strc_t.delete(); strc_cmd.delete(); vch_log.delete(); done_cnt = 0;
    #2 rst = 0;
    rel_t = cyc;
    for (int i = 0; i < 1500 && strc_t.size() < 1; i++) @(negedge clk);
    n_vec++; if (strc_t.size() < 1 || strc_t[0] - rel_t != 1001)
      begin n_err++; $display("FAIL rmid_restart got n=%0d dt=%0d want dt 1001", strc_t.size(), strc_t[0] - rel_t); end
    en = 0;
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; chmask = 2'b00; period = '0;
    test_reset();
    test_basic();
    test_single();
    test_overrun();
    test_timeout();
    test_en_mask();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
